operand_collector: RTL
======================

Name: operand_collector

Overview:
- Consumer side of the valid-register operand protocol (write-enable / ready / clear).
- Watches the ready flags of NumOperands upstream operand registers. When all are ready, it captures their data and issues one bundle to a downstream FP datapath with a valid/ready handshake.
- After the bundle is accepted, it pulses clear back to every operand register so they can be refilled.
- Sits between the operand register file and each pipelined FP unit generated in PipeGen.

Parameters:
- DataWidth, 32, width of one operand.
- NumOperands, 2, number of operand registers collected per issue (1..8).
- CountWidth, 16, width of the issue counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  global pipeline stall; freezes all state.
- op_rdy  in  NumOperands  ready flag from each operand register.
- op_data  in  NumOperands*DataWidth  operand data; operand i occupies bits [i*DataWidth +: DataWidth].
- op_clr  out  NumOperands  clear request to each operand register.
- op_busy  out  NumOperands  operand is captured and awaiting clear; producer must not write it.
- issue_valid  out  1  issue_data is valid.
- issue_ready  in  1  downstream accepts the bundle.
- issue_data  out  NumOperands*DataWidth  captured operand bundle, same packing as op_data.
- issue_count  out  CountWidth  number of accepted bundles, wraps modulo 2^CountWidth.

Behaviour:
- Reset (asynchronous, any time, including mid-issue):
  - State returns to WAIT.
  - issue_valid=0, issue_data=0, op_clr=0, op_busy=0, issue_count=0.
  - A bundle in flight is dropped with no clear pulse.
- FSM states: WAIT, ISSUE, CLEAR. Every transition is blocked while stall=1, and no register changes while stall=1.
- WAIT:
  - If op_rdy is all ones and stall=0: register op_data into issue_data, go to ISSUE.
  - Any partial op_rdy pattern: stay in WAIT and hold issue_data.
- ISSUE:
  - issue_valid=1 and op_busy all ones.
  - issue_data is stable for the whole state.
  - If issue_ready=1 and stall=0: issue_count increments by 1 (wrapping), go to CLEAR.
  - If issue_ready=0: hold indefinitely.
- CLEAR:
  - op_clr all ones, op_busy all ones, issue_valid=0.
  - If stall=0: go to WAIT. The operand registers sample clr on this same edge.
  - If stall=1: hold CLEAR with op_clr still high, so the clear is not lost (operand registers ignore clr while stalled).
- Outputs are Moore, decoded from registered state. op_clr=0 and op_busy=0 in WAIT; issue_valid=0 outside ISSUE.
- Latency:
  - All-ready edge → issue_valid=1 on the next cycle.
  - Acceptance edge → op_clr high for exactly one cycle (absent stall).
  - WAIT can re-capture one cycle after CLEAR, so peak throughput is 1 bundle per 3 cycles.
- Simultaneous events:
  - A producer write coinciding with the CLEAR edge wins in the operand register (its rdy stays 1). That new operand is collected normally in the following WAIT.
  - stall together with issue_ready=1 is not an acceptance; the count is unchanged.
- op_rdy and op_data changes during ISSUE or CLEAR are ignored.

Decomposition:
- Shared package: FSM state encoding (WAIT=2'd0, ISSUE=2'd1, CLEAR=2'd2) and default width constants.
- No sub-module needed. The capture register, issue counter, and FSM stay in one module.

Test Plan:
- Reset → all outputs 0. Then op_rdy=2'b11, op_data={32'h4000_0000, 32'h3F80_0000}, issue_ready=1 → issue_valid=1 the next cycle with that data, op_clr=2'b11 for one cycle, issue_count=1.
- op_rdy=2'b01 held 10 cycles → stays in WAIT, issue_valid=0, op_clr=0. Raising op_rdy[1] → issue 1 cycle later.
- issue_ready=0 for 5 cycles while op_data changes to 32'hDEAD_BEEF → issue_data holds the captured value, and op_busy=2'b11 throughout.
- Stall asserted for 3 cycles in CLEAR → op_clr stays 2'b11 all 4 cycles; WAIT resumes the cycle after stall drops. Stall in ISSUE with issue_ready=1 → no count change.
- CountWidth=4, 17 back-to-back bundles → issue_count wraps to 1; bundles spaced 3 cycles apart.
- rst pulsed mid-ISSUE → issue_valid and op_busy drop immediately, no op_clr pulse, issue_count=0.

Source files
------------

// File: rtl/operand_collector_pkg.sv
// Shared definitions for the operand collector: FSM encoding and default widths.
package operand_collector_pkg;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CLEAR = 2'd2
   } oc_state_t;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_NUM_OPERANDS = 2;
   localparam int DEF_COUNT_WIDTH  = 16;

endpackage

// File: rtl/operand_collector.sv
// Collects NumOperands ready operands, issues them as one bundle downstream,
// then pulses clear back to the operand registers.
module operand_collector
   import operand_collector_pkg::*;
#(
   parameter int DataWidth   = DEF_DATA_WIDTH,
   parameter int NumOperands = DEF_NUM_OPERANDS,
   parameter int CountWidth  = DEF_COUNT_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic [NumOperands-1:0]           op_rdy,
   input  logic [NumOperands*DataWidth-1:0] op_data,
   output logic [NumOperands-1:0]           op_clr,
   output logic [NumOperands-1:0]           op_busy,
   output logic                             issue_valid,
   input  logic                             issue_ready,
   output logic [NumOperands*DataWidth-1:0] issue_data,
   output logic [CountWidth-1:0]            issue_count,
   output logic [1:0]                       dbg_state
);

   // Handshake: a bundle transfers on a rising edge where issue_valid=1,
   // issue_ready=1 and stall=0; issue_data is held stable while issue_valid=1.

   oc_state_t                        state_q, state_d;
   logic [NumOperands*DataWidth-1:0] data_q;
   logic [CountWidth-1:0]            count_q;
   logic                             capture;
   logic                             accept;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (&op_rdy) begin
               capture = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (issue_ready) begin
               accept  = 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            state_d = ST_WAIT;
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // Stall gates every register, so a held CLEAR keeps op_clr asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_WAIT;
         data_q  <= '0;
         count_q <= '0;
      end else if (!stall) begin
         state_q <= state_d;
         if (capture) begin
            data_q <= op_data;
         end
         if (accept) begin
            count_q <= count_q + CountWidth'(1);
         end
      end
   end

   always_comb begin
      issue_valid = (state_q == ST_ISSUE);
      op_busy     = {NumOperands{(state_q == ST_ISSUE) || (state_q == ST_CLEAR)}};
      op_clr      = {NumOperands{(state_q == ST_CLEAR)}};
      issue_data  = data_q;
      issue_count = count_q;
      dbg_state   = state_q;
   end

endmodule
